// File: rtl/vscale_hasti_arbiter_if.sv
// HASTI (AHB-Lite subset) bus bundle shared by masters, the arbiter and the slave.
//   master modport: drives the address phase and hwdata; receives hrdata, hready and hresp.
//   slave  modport: receives the address phase and hwdata; drives hrdata, hready and hresp.
interface vscale_hasti_arbiter_if;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SIZE_W  = 3;
    localparam int unsigned BURST_W = 3;
    localparam int unsigned PROT_W  = 4;
    localparam int unsigned TRANS_W = 2;

    logic [ADDR_W-1:0]  haddr;
    logic               hwrite;
    logic [SIZE_W-1:0]  hsize;
    logic [BURST_W-1:0] hburst;
    logic               hmastlock;
    logic [PROT_W-1:0]  hprot;
    logic [TRANS_W-1:0] htrans;
    logic [DATA_W-1:0]  hwdata;
    logic [DATA_W-1:0]  hrdata;
    logic               hready;
    logic               hresp;

    modport master (
        output haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
        input  hrdata, hready, hresp
    );

    modport slave (
        input  haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
        output hrdata, hready, hresp
    );
endinterface

// File: rtl/vscale_hasti_arbiter.sv
// Two-master to one-slave HASTI arbiter placed in front of the SRAM slave.
// m0 (instruction port) and m1 (data port) share one slave port; the address-phase
// grant and the data-phase owner are tracked separately so transfers interleave.
// Ports:
//   hclk, hreset : clock, synchronous active-high reset
//   m0, m1       : slave-side views of the two masters' buses
//   s            : master-side view of the downstream slave bus
// Optional feature: define HASTI_ARB_ROUND_ROBIN_EN to alternate the grant between
// two simultaneous requesters; without it m0 has fixed priority over m1.
module vscale_hasti_arbiter (
    input  logic                   hclk,
    input  logic                   hreset,
    vscale_hasti_arbiter_if.slave  m0,
    vscale_hasti_arbiter_if.slave  m1,
    vscale_hasti_arbiter_if.master s
);
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned SIZE_W  = 3;
    localparam int unsigned BURST_W = 3;
    localparam int unsigned PROT_W  = 4;
    localparam int unsigned TRANS_W = 2;

    localparam logic [TRANS_W-1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [TRANS_W-1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [TRANS_W-1:0] HTRANS_SEQ    = 2'b11;
    localparam logic               HRESP_OKAY    = 1'b0;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic               write;
        logic [SIZE_W-1:0]  size;
        logic [BURST_W-1:0] burst;
        logic               lock;
        logic [PROT_W-1:0]  prot;
        logic [TRANS_W-1:0] trans;
    } addr_phase_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_e;

    // NONSEQ/SEQ carry a real transfer; IDLE and BUSY do not.
    function automatic logic trans_active(input logic [TRANS_W-1:0] t);
        return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
    endfunction

    // last_q encodes the last granted master: 0 = m0, 1 = m1.
    owner_e      owner_q, owner_d;
    logic        last_q, last_d;
    logic        last_lock_q, last_lock_d;
    logic        pend0_vld_q, pend0_vld_d;
    logic        pend1_vld_q, pend1_vld_d;
    addr_phase_t pend0_q, pend0_d;
    addr_phase_t pend1_q, pend1_d;

    addr_phase_t live0, live1, src0, src1, fwd;
    logic        req0, req1;
    logic        gnt_vld, gnt_m1, gnt0, gnt1;
    logic        m0_hready_c, m1_hready_c;
    logic        m0_hresp_c, m1_hresp_c;

    // Live address phases and the source each master would forward (buffered entry first).
    always_comb begin
        live0 = '{addr: m0.haddr, write: m0.hwrite, size: m0.hsize, burst: m0.hburst,
                  lock: m0.hmastlock, prot: m0.hprot, trans: m0.htrans};
        live1 = '{addr: m1.haddr, write: m1.hwrite, size: m1.hsize, burst: m1.hburst,
                  lock: m1.hmastlock, prot: m1.hprot, trans: m1.htrans};
        src0  = pend0_vld_q ? pend0_q : live0;
        src1  = pend1_vld_q ? pend1_q : live1;
        req0  = pend0_vld_q || trans_active(live0.trans);
        req1  = pend1_vld_q || trans_active(live1.trans);
    end

    // Address-phase grant: a locked sequence keeps the bus, otherwise resolve contention.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_m1  = 1'b0;
        if (last_lock_q && (last_q ? req1 : req0)) begin
            gnt_vld = 1'b1;
            gnt_m1  = last_q;
        end else if (req0 && req1) begin
            gnt_vld = 1'b1;
`ifdef HASTI_ARB_ROUND_ROBIN_EN
            gnt_m1  = ~last_q;
`else
            gnt_m1  = 1'b0;
`endif
        end else if (req0) begin
            gnt_vld = 1'b1;
        end else if (req1) begin
            gnt_vld = 1'b1;
            gnt_m1  = 1'b1;
        end
        gnt0 = gnt_vld && !gnt_m1;
        gnt1 = gnt_vld && gnt_m1;
    end

    // Forwarded address phase; with no requester (or in reset) m0's fields go out as IDLE.
    always_comb begin
        fwd = gnt1 ? src1 : src0;
        if (!gnt_vld || hreset) begin
            fwd.trans = HTRANS_IDLE;
        end
    end

    // Next state: everything advances only when the slave accepts (s.hready).
    always_comb begin
        owner_d     = owner_q;
        last_d      = last_q;
        last_lock_d = last_lock_q;
        pend0_vld_d = pend0_vld_q;
        pend1_vld_d = pend1_vld_q;
        pend0_d     = pend0_q;
        pend1_d     = pend1_q;
        if (s.hready) begin
            if (gnt_vld && trans_active(fwd.trans)) begin
                owner_d = gnt_m1 ? OWN_M1 : OWN_M0;
            end else begin
                owner_d = OWN_NONE;
            end
            if (gnt_vld) begin
                last_d      = gnt_m1;
                last_lock_d = fwd.lock;
            end else begin
                last_lock_d = 1'b0;
            end
            if (gnt0 && pend0_vld_q) begin
                pend0_vld_d = 1'b0;
            end
            if (gnt1 && pend1_vld_q) begin
                pend1_vld_d = 1'b0;
            end
            // The owner saw hready high, so its new address was acknowledged even
            // though the other master won the bus; hold it until it can be issued.
            if ((owner_q == OWN_M0) && !gnt0 && trans_active(live0.trans)) begin
                pend0_vld_d = 1'b1;
                pend0_d     = live0;
            end
            if ((owner_q == OWN_M1) && !gnt1 && trans_active(live1.trans)) begin
                pend1_vld_d = 1'b1;
                pend1_d     = live1;
            end
        end
    end

    // State register.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            owner_q     <= OWN_NONE;
            last_q      <= 1'b1;
            last_lock_q <= 1'b0;
            pend0_vld_q <= 1'b0;
            pend1_vld_q <= 1'b0;
            pend0_q     <= '0;
            pend1_q     <= '0;
        end else begin
            owner_q     <= owner_d;
            last_q      <= last_d;
            last_lock_q <= last_lock_d;
            pend0_vld_q <= pend0_vld_d;
            pend1_vld_q <= pend1_vld_d;
            pend0_q     <= pend0_d;
            pend1_q     <= pend1_d;
        end
    end

    // Per-master ready and response.
    always_comb begin
        m0_hready_c = 1'b1;
        m1_hready_c = 1'b1;
        m0_hresp_c  = HRESP_OKAY;
        m1_hresp_c  = HRESP_OKAY;
        if (!hreset) begin
            if (owner_q == OWN_M0)               m0_hready_c = s.hready;
            else if (pend0_vld_q || (req0 && !gnt0)) m0_hready_c = 1'b0;
            else if (gnt0)                       m0_hready_c = s.hready;

            if (owner_q == OWN_M1)               m1_hready_c = s.hready;
            else if (pend1_vld_q || (req1 && !gnt1)) m1_hready_c = 1'b0;
            else if (gnt1)                       m1_hready_c = s.hready;

            if (owner_q == OWN_M0) m0_hresp_c = s.hresp;
            if (owner_q == OWN_M1) m1_hresp_c = s.hresp;
        end
    end

    assign s.haddr     = fwd.addr;
    assign s.hwrite    = fwd.write;
    assign s.hsize     = fwd.size;
    assign s.hburst    = fwd.burst;
    assign s.hmastlock = fwd.lock;
    assign s.hprot     = fwd.prot;
    assign s.htrans    = fwd.trans;
    assign s.hwdata    = (owner_q == OWN_M1) ? m1.hwdata : m0.hwdata;

    assign m0.hrdata = s.hrdata;
    assign m1.hrdata = s.hrdata;
    assign m0.hready = m0_hready_c;
    assign m1.hready = m1_hready_c;
    assign m0.hresp  = m0_hresp_c;
    assign m1.hresp  = m1_hresp_c;
endmodule

// File: tb/tb_vscale_hasti_arbiter.sv
// Directed bench for vscale_hasti_arbiter: two masters and a slave model driven
// cycle by cycle, outputs sampled 1-2 time units after the rising edge.
module tb_vscale_hasti_arbiter;
    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    logic hclk;
    logic hreset;
    int   n_chk;
    int   n_bad;

    vscale_hasti_arbiter_if m0_if ();
    vscale_hasti_arbiter_if m1_if ();
    vscale_hasti_arbiter_if s_if ();

    vscale_hasti_arbiter dut (
        .hclk   (hclk),
        .hreset (hreset),
        .m0     (m0_if),
        .m1     (m1_if),
        .s      (s_if)
    );

    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic set_m0(input logic [1:0] tr, input logic [31:0] a, input logic wr, input logic lk);
        m0_if.htrans    = tr;
        m0_if.haddr     = a;
        m0_if.hwrite    = wr;
        m0_if.hmastlock = lk;
    endtask

    task automatic set_m1(input logic [1:0] tr, input logic [31:0] a, input logic wr, input logic lk);
        m1_if.htrans    = tr;
        m1_if.haddr     = a;
        m1_if.hwrite    = wr;
        m1_if.hmastlock = lk;
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        hreset = 1'b1;
        set_m0(T_IDLE, 32'h0, 1'b0, 1'b0);
        set_m1(T_IDLE, 32'h0, 1'b0, 1'b0);
        m0_if.hsize = 3'b010; m0_if.hburst = 3'b000; m0_if.hprot = 4'b0011; m0_if.hwdata = 32'h0;
        m1_if.hsize = 3'b010; m1_if.hburst = 3'b000; m1_if.hprot = 4'b0011; m1_if.hwdata = 32'h0;
        s_if.hready = 1'b1;
        s_if.hresp  = 1'b0;
        s_if.hrdata = 32'h0;
        step();
        step();

        // Reset asserted: requests are masked and masters see ready/OKAY.
        set_m0(T_NONSEQ, 32'h100, 1'b0, 1'b0);
        s_if.hresp = 1'b1;
        #1;
        check("rst_htrans",  32'(s_if.htrans),   32'(T_IDLE));
        check("rst_m0_rdy",  32'(m0_if.hready),  32'd1);
        check("rst_m1_rdy",  32'(m1_if.hready),  32'd1);
        check("rst_m0_resp", 32'(m0_if.hresp),   32'd0);
        s_if.hresp = 1'b0;
        hreset = 1'b0;
        set_m0(T_IDLE, 32'h0, 1'b0, 1'b0);
        step();

        // Uncontended m0 read: zero added latency, data returned to m0.
        set_m0(T_NONSEQ, 32'h100, 1'b0, 1'b0);
        s_if.hrdata = 32'hA5A5_0100;
        #1;
        check("t1_addr",   s_if.haddr,         32'h100);
        check("t1_trans",  32'(s_if.htrans),   32'(T_NONSEQ));
        check("t1_m0_rdy", 32'(m0_if.hready),  32'd1);
        step();
        set_m0(T_IDLE, 32'h0, 1'b0, 1'b0);
        s_if.hresp = 1'b1;
        #1;
        check("t1_rdata",   m0_if.hrdata,      32'hA5A5_0100);
        check("t1_m0_resp", 32'(m0_if.hresp),  32'd1);
        check("t1_m1_resp", 32'(m1_if.hresp),  32'd0);
        check("t1_idle",    32'(s_if.htrans),  32'(T_IDLE));
        s_if.hresp = 1'b0;
        step();

        // Simultaneous requests: m0 first, m1 write follows, its data in its data phase.
        set_m0(T_NONSEQ, 32'h200, 1'b0, 1'b0);
        set_m1(T_NONSEQ, 32'h300, 1'b1, 1'b0);
        #1;
        check("t2_a_addr",   s_if.haddr,        32'h200);
        check("t2_a_m1_rdy", 32'(m1_if.hready), 32'd0);
        check("t2_a_m0_rdy", 32'(m0_if.hready), 32'd1);
        step();
        set_m0(T_IDLE, 32'h0, 1'b0, 1'b0);
        #1;
        check("t2_b_addr",   s_if.haddr,        32'h300);
        check("t2_b_write",  32'(s_if.hwrite),  32'd1);
        check("t2_b_m1_rdy", 32'(m1_if.hready), 32'd1);
        step();
        set_m1(T_IDLE, 32'h0, 1'b0, 1'b0);
        m1_if.hwdata = 32'hDEAD_BEEF;
        m0_if.hwdata = 32'h1111_1111;
        #1;
        check("t2_wdata", s_if.hwdata, 32'hDEAD_BEEF);
        step();

        // m1 back-to-back while m0 wins the second cycle: 0x44 is buffered, issued once.
        set_m1(T_NONSEQ, 32'h40, 1'b0, 1'b0);
        #1;
        check("t3_a_addr",   s_if.haddr,        32'h40);
        check("t3_a_m1_rdy", 32'(m1_if.hready), 32'd1);
        step();
        set_m1(T_SEQ, 32'h44, 1'b0, 1'b0);
        set_m0(T_NONSEQ, 32'h500, 1'b0, 1'b0);
        #1;
        check("t3_b_addr",   s_if.haddr,        32'h500);
        check("t3_b_m1_rdy", 32'(m1_if.hready), 32'd1);
        step();
        set_m1(T_IDLE, 32'h0, 1'b0, 1'b0);
        set_m0(T_IDLE, 32'h0, 1'b0, 1'b0);
        #1;
        check("t3_c_addr",   s_if.haddr,        32'h44);
        check("t3_c_trans",  32'(s_if.htrans),  32'(T_SEQ));
        check("t3_c_m1_rdy", 32'(m1_if.hready), 32'd0);
        step();
        #1;
        check("t3_d_trans",  32'(s_if.htrans),  32'(T_IDLE));
        check("t3_d_m1_rdy", 32'(m1_if.hready), 32'd1);
        step();
        #1;
        check("t3_e_trans",  32'(s_if.htrans),  32'(T_IDLE));

        // Two slave wait states during an m0 data phase.
        set_m0(T_NONSEQ, 32'h600, 1'b0, 1'b0);
        #1;
        check("t4_a_addr", s_if.haddr, 32'h600);
        step();
        set_m0(T_IDLE, 32'h0, 1'b0, 1'b0);
        set_m1(T_NONSEQ, 32'h700, 1'b0, 1'b0);
        s_if.hready = 1'b0;
        #1;
        check("t4_w1_m0_rdy", 32'(m0_if.hready), 32'd0);
        check("t4_w1_m1_rdy", 32'(m1_if.hready), 32'd0);
        check("t4_w1_addr",   s_if.haddr,        32'h700);
        step();
        #1;
        check("t4_w2_m0_rdy", 32'(m0_if.hready), 32'd0);
        check("t4_w2_m1_rdy", 32'(m1_if.hready), 32'd0);
        check("t4_w2_addr",   s_if.haddr,        32'h700);
        step();
        s_if.hready = 1'b1;
        #1;
        check("t4_c_m0_rdy", 32'(m0_if.hready), 32'd1);
        check("t4_c_m1_rdy", 32'(m1_if.hready), 32'd1);
        step();
        set_m1(T_IDLE, 32'h0, 1'b0, 1'b0);
        s_if.hresp = 1'b1;
        #1;
        check("t4_d_m1_resp", 32'(m1_if.hresp), 32'd1);
        check("t4_d_m0_resp", 32'(m0_if.hresp), 32'd0);
        s_if.hresp = 1'b0;
        step();

        // m1 locked sequence of three transfers holds off m0.
        set_m1(T_NONSEQ, 32'h800, 1'b0, 1'b1);
        #1;
        check("t5_a_addr", s_if.haddr, 32'h800);
        step();
        set_m1(T_SEQ, 32'h804, 1'b0, 1'b1);
        set_m0(T_NONSEQ, 32'h900, 1'b0, 1'b0);
        #1;
        check("t5_b_addr",   s_if.haddr,          32'h804);
        check("t5_b_lock",   32'(s_if.hmastlock), 32'd1);
        check("t5_b_m0_rdy", 32'(m0_if.hready),   32'd0);
        step();
        set_m1(T_SEQ, 32'h808, 1'b0, 1'b1);
        #1;
        check("t5_c_addr",   s_if.haddr,        32'h808);
        check("t5_c_m0_rdy", 32'(m0_if.hready), 32'd0);
        step();
        set_m1(T_IDLE, 32'h0, 1'b0, 1'b0);
        #1;
        check("t5_d_addr",   s_if.haddr,        32'h900);
        check("t5_d_m0_rdy", 32'(m0_if.hready), 32'd1);
        step();
        set_m0(T_IDLE, 32'h0, 1'b0, 1'b0);
        #1;
        check("t5_e_trans", 32'(s_if.htrans), 32'(T_IDLE));
        step();

        // Reset during an m0 write data phase drops it.
        set_m0(T_NONSEQ, 32'hC00, 1'b1, 1'b0);
        #1;
        check("t6_a_addr", s_if.haddr, 32'hC00);
        step();
        set_m0(T_IDLE, 32'h0, 1'b0, 1'b0);
        m0_if.hwdata = 32'h1234_5678;
        set_m1(T_NONSEQ, 32'hD00, 1'b0, 1'b0);
        hreset = 1'b1;
        #1;
        check("t6_r_trans",  32'(s_if.htrans),  32'(T_IDLE));
        check("t6_r_m0_rdy", 32'(m0_if.hready), 32'd1);
        check("t6_r_m1_rdy", 32'(m1_if.hready), 32'd1);
        step();
        hreset = 1'b0;
        set_m1(T_IDLE, 32'h0, 1'b0, 1'b0);
        s_if.hresp = 1'b1;
        #1;
        check("t6_n_trans",   32'(s_if.htrans),  32'(T_IDLE));
        check("t6_n_m0_rdy",  32'(m0_if.hready), 32'd1);
        check("t6_n_m1_rdy",  32'(m1_if.hready), 32'd1);
        check("t6_n_m0_resp", 32'(m0_if.hresp),  32'd0);
        check("t6_n_m1_resp", 32'(m1_if.hresp),  32'd0);
        s_if.hresp = 1'b0;
        step();

        // Continuous requests from both masters.
        set_m0(T_NONSEQ, 32'hA00, 1'b0, 1'b0);
        set_m1(T_NONSEQ, 32'hB00, 1'b0, 1'b0);
        #1;
        check("t7_1_addr", s_if.haddr, 32'hA00);
        step();
        set_m0(T_SEQ, 32'hA04, 1'b0, 1'b0);
        #1;
`ifdef HASTI_ARB_ROUND_ROBIN_EN
        check("t7_2_addr",   s_if.haddr,        32'hB00);
        check("t7_2_m1_rdy", 32'(m1_if.hready), 32'd1);
`else
        check("t7_2_addr",   s_if.haddr,        32'hA04);
        check("t7_2_m1_rdy", 32'(m1_if.hready), 32'd0);
`endif
        step();
        set_m0(T_SEQ, 32'hA08, 1'b0, 1'b0);
`ifdef HASTI_ARB_ROUND_ROBIN_EN
        set_m1(T_SEQ, 32'hB04, 1'b0, 1'b0);
        #1;
        check("t7_3_addr", s_if.haddr, 32'hA04);
`else
        #1;
        check("t7_3_addr",   s_if.haddr,        32'hA08);
        check("t7_3_m1_rdy", 32'(m1_if.hready), 32'd0);
`endif
        step();
        set_m0(T_IDLE, 32'h0, 1'b0, 1'b0);
        set_m1(T_IDLE, 32'h0, 1'b0, 1'b0);
        step();
        step();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
